// File: rtl/pc_sequencer_if.sv
// Fetch-PC sequencer bus: redirect/stall requests in, fetch PC and status out.
// The master side is the pipeline control (hazard unit, CP0, NPC mux); the slave is the sequencer.
interface pc_sequencer_if;
    logic        stall_i;
    logic [31:0] npc_i;
    logic        exc_req_i;
    logic        eret_req_i;
    logic [31:0] epc_i;
    logic [31:0] pc_o;
    logic [31:0] pc4_o;
    logic        fetch_valid_o;
    logic        flush_o;
    logic        adel_o;
    logic        hang_o;
    logic [1:0]  state_o;

    modport master (
        output stall_i, npc_i, exc_req_i, eret_req_i, epc_i,
        input  pc_o, pc4_o, fetch_valid_o, flush_o, adel_o, hang_o, state_o
    );

    modport slave (
        input  stall_i, npc_i, exc_req_i, eret_req_i, epc_i,
        output pc_o, pc4_o, fetch_valid_o, flush_o, adel_o, hang_o, state_o
    );
endinterface

// File: rtl/pc_sequencer.sv
// Fetch PC register and next-PC selection: boot cycle, exception/eret redirect with a
// one-cycle bubble, stall hold with a sticky watchdog, and fetch-address checking.
module pc_sequencer #(
    parameter logic [31:0] RESET_PC  = 32'h0000_3000,
    parameter logic [31:0] EXC_VEC   = 32'h0000_4180,
    parameter logic [31:0] IM_BASE   = 32'h0000_3000,
    parameter logic [31:0] IM_LIMIT  = 32'h0000_6FFC,
    parameter logic [7:0]  MAX_STALL = 8'd64
) (
    input  logic           clk,
    input  logic           reset,
    pc_sequencer_if.slave  bus
);

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        STALL = 2'd2,
        REDIR = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        flush_q, flush_d;
    logic        hang_q, hang_d;
    logic [7:0]  stall_cnt_q, stall_cnt_d;
    logic        adel;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= BOOT;
            pc_q        <= RESET_PC;
            flush_q     <= 1'b0;
            hang_q      <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            flush_q     <= flush_d;
            hang_q      <= hang_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        flush_d     = 1'b0;
        stall_cnt_d = '0;
        hang_d      = hang_q;
        if (state_q == BOOT) begin
            state_d = RUN;
        end else if (bus.exc_req_i) begin
            pc_d    = EXC_VEC;
            flush_d = 1'b1;
            state_d = REDIR;
        end else if (bus.eret_req_i) begin
            pc_d    = bus.epc_i;
            flush_d = 1'b1;
            state_d = REDIR;
        end else if (state_q == REDIR) begin
            // bubble cycle: the target is already in pc_q, stall is not honoured here
            state_d = RUN;
        end else if (bus.stall_i) begin
            state_d     = STALL;
            stall_cnt_d = (stall_cnt_q == 8'hFF) ? stall_cnt_q : stall_cnt_q + 8'd1;
        end else begin
            pc_d    = bus.npc_i;
            state_d = RUN;
        end
        // flag rises on the same edge the count reaches the limit
        if (stall_cnt_d == MAX_STALL) begin
            hang_d = 1'b1;
        end
    end

    assign adel = (pc_q[1:0] != 2'b00) || (pc_q < IM_BASE) || (pc_q > IM_LIMIT);

    assign bus.pc_o          = pc_q;
    assign bus.pc4_o         = pc_q + 32'd4;
    assign bus.adel_o        = adel;
    assign bus.fetch_valid_o = ((state_q == RUN) || (state_q == STALL)) && !adel;
    assign bus.flush_o       = flush_q;
    assign bus.hang_o        = hang_q;
    assign bus.state_o       = state_q;

endmodule
